xgemac_rx_pkt_reader: RTL and testbench
=======================================

# xgemac_rx_pkt_reader

Synthesizable consumer for the XGEMAC receive packet interface, used in the 156.25 MHz core clock domain. It pulls frames from the MAC with the `pkt_rx_avail`/`pkt_rx_ren` handshake and checks SOP/EOP framing. It buffers words in an internal show-ahead FIFO and presents them on a valid/ready stream, with frame and error statistics for the Wishbone register block. It is the read-side counterpart of the packet path that the XGEMAC testbench drives on the transmit side.

## Interface
- `FIFO_DEPTH`, default 16: FIFO entries; power of two, ≥4.
- `FRM_CNT_W`, default 32: frame counter width.
- `ERR_CNT_W`, default 16: error counter width.

- `clk_156m25` — in — 1 — core clock; all logic on its rising edge.
- `reset_156m25_n` — in — 1 — reset: one clock; reset is asynchronous and active-low.
- `pkt_rx_avail` — in — 1 — MAC has at least one frame ready.
- `pkt_rx_ren` — out — 1 — read request; data returns one cycle later.
- `pkt_rx_val` — in — 1 — `pkt_rx_data` is valid this cycle.
- `pkt_rx_data` — in — 64 — receive word.
- `pkt_rx_sop` — in — 1 — first word of frame.
- `pkt_rx_eop` — in — 1 — last word of frame.
- `pkt_rx_mod` — in — 3 — valid bytes in EOP word; 0 means 8.
- `pkt_rx_err` — in — 1 — MAC error, meaningful on EOP word.
- `out_valid` — out — 1 — stream word available.
- `out_ready` — in — 1 — downstream accepts.
- `out_data` — out — 64 — stream data.
- `out_sop` — out — 1 — stream SOP.
- `out_eop` — out — 1 — stream EOP.
- `out_mod` — out — 3 — stream mod.
- `out_err` — out — 1 — frame bad; valid on EOP word.
- `clr_stats` — in — 1 — synchronous clear of all counters.
- `frame_cnt` — out — `FRM_CNT_W` — frames pushed, counted at the EOP word.
- `err_cnt` — out — `ERR_CNT_W` — erroneous frames plus dropped words.
- `byte_cnt` — out — 48 — present only with `XGEMAC_RX_READER_BYTE_CNT_EN`.

## Operation
- The FSM has two states, `IDLE` and `READ`.
- `IDLE` → `READ` when `pkt_rx_avail=1` and the FIFO space check passes.
- `READ` → `IDLE` on the cycle a word with `pkt_rx_val & pkt_rx_eop` is received.
- `pkt_rx_ren = (state==READ) & (count + ren_q + 1 <= FIFO_DEPTH) & ~(pkt_rx_val & pkt_rx_eop)`.
  - `ren_q` is the registered `pkt_rx_ren`, i.e. the word in flight.
  - The mask guarantees no read beyond EOP.
- Framing tracker `in_frame`:
  - A word with `val & sop` sets it.
  - A word with `val & eop` clears it.
- Missing SOP (`val`, `~in_frame`, `~sop`): the word is dropped, not pushed; `err_cnt++`.
- SOP while `in_frame`: the word is pushed with SOP stripped and sticky `frm_bad` is set. That frame's EOP word carries `out_err=1`.
- Single-word frame: SOP and EOP both set; pushed once.
- Pushed `err` = `pkt_rx_err | frm_bad` on the EOP word, 0 otherwise. `frm_bad` clears after the EOP push.
- Counters: `frame_cnt++` on every EOP push; `err_cnt++` on every EOP push with err=1.
  - `frame_cnt` and `err_cnt` saturate at all-ones.
  - `clr_stats` zeroes them. If `clr_stats` coincides with an increment, the clear wins.
- FIFO is show-ahead.
  - `out_*` = head entry.
  - `out_valid = ~empty`.
  - Pop on `out_valid & out_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
- Overflow is impossible by construction. If a `val` word arrives with the FIFO full, it is dropped and `err_cnt++` (a defensive check that must never fire in verification).

## Timing
- Word with `pkt_rx_val` in cycle T → `out_valid` in T+1 if the FIFO was empty.
- `pkt_rx_ren` in cycle T → `pkt_rx_val` expected in T+1 (MAC contract).
- `IDLE` → first `pkt_rx_ren` in the cycle after `pkt_rx_avail` is sampled.
- Reset values:
  - `pkt_rx_ren=0`, `out_valid=0`.
  - `out_data/sop/eop/mod/err=0`.
  - All counters 0, state `IDLE`, `in_frame=0`, `frm_bad=0`, FIFO empty.
- Reset asserted mid-frame discards the FIFO and partial-frame state immediately. After release the block waits in `IDLE` for `pkt_rx_avail`; a trailing non-SOP word counts as a missing-SOP error.

## Configuration
- `XGEMAC_RX_READER_BYTE_CNT_EN` defined:
  - A 48-bit wrapping `byte_cnt` is added.
  - +8 per pushed non-EOP word.
  - +(`mod==0 ? 8 : mod`) per pushed EOP word.
  - Cleared by `clr_stats` and by reset.
- Undefined: the `byte_cnt` port and its logic are absent.

## Test plan
- 64-byte frame: 8 words, mod=0, `out_ready=1` → 8 output words, SOP on the 1st, EOP on the 8th, `frame_cnt=1`, `err_cnt=0`, `byte_cnt=64`.
- 61-byte frame: 8 words, mod=5 → `out_mod=5` on EOP, `byte_cnt=61`.
- 40-word frame with `out_ready=0` and `FIFO_DEPTH=16` → `pkt_rx_ren` stops with exactly 16 entries, no drop. Releasing `out_ready` completes all 40 words in order.
- EOP word with `pkt_rx_err=1` → `out_err=1` on EOP only, `err_cnt=1`, `frame_cnt=1`.
- Word without SOP while idle → not output, `err_cnt=1`. SOP mid-frame → SOP stripped, `out_err=1` at EOP.
- Reset asserted at word 3 of 8 → all outputs 0 within the same cycle. The next 4-word frame is received intact and `frame_cnt=1`.

Source files
------------

// File: rtl/xgemac_rx_pkt_reader.sv
// XGEMAC receive packet reader: pulls frames over pkt_rx_avail/pkt_rx_ren, checks SOP/EOP framing and
// presents words through a show-ahead FIFO. Define XGEMAC_RX_READER_BYTE_CNT_EN to add the 48-bit byte counter.
module xgemac_rx_pkt_reader #(
  parameter int FIFO_DEPTH = 16,
  parameter int FRM_CNT_W  = 32,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk_156m25,
  input  logic                 reset_156m25_n,
  input  logic                 pkt_rx_avail,
  output logic                 pkt_rx_ren,
  input  logic                 pkt_rx_val,
  input  logic [63:0]          pkt_rx_data,
  input  logic                 pkt_rx_sop,
  input  logic                 pkt_rx_eop,
  input  logic [2:0]           pkt_rx_mod,
  input  logic                 pkt_rx_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [2:0]           out_mod,
  output logic                 out_err,
  input  logic                 clr_stats,
  output logic [FRM_CNT_W-1:0] frame_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef XGEMAC_RX_READER_BYTE_CNT_EN
  ,
  output logic [47:0]          byte_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, READ} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
  } entry_t;

  state_t        state, state_next;
  logic          ren_q;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  entry_t        mem [FIFO_DEPTH];
  entry_t        head, push_entry;
  logic          full, empty, space_ok, rx_last;
  logic          push, pop, drop, bad_sop;
  logic          in_frame, frm_bad;
  logic          frame_inc, err_inc;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign rx_last  = pkt_rx_val & pkt_rx_eop;
  // Room for one more word after the one possibly still in flight from last cycle's read.
  assign space_ok = (count + CW'(ren_q)) < DEPTH_C;

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state <= IDLE;
      ren_q <= 1'b0;
    end else begin
      state <= state_next;
      ren_q <= pkt_rx_ren;
    end
  end

  always_comb begin
    state_next = state;
    pkt_rx_ren = 1'b0;
    case (state)
      IDLE: if (pkt_rx_avail && space_ok) state_next = READ;
      READ: begin
        pkt_rx_ren = space_ok && !rx_last;
        if (rx_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    push       = 1'b0;
    drop       = 1'b0;
    bad_sop    = 1'b0;
    push_entry = '0;
    if (pkt_rx_val) begin
      if (full || (!in_frame && !pkt_rx_sop)) begin
        drop = 1'b1;
      end else begin
        push            = 1'b1;
        bad_sop         = pkt_rx_sop & in_frame;
        push_entry.data = pkt_rx_data;
        push_entry.sop  = pkt_rx_sop & ~in_frame;
        push_entry.eop  = pkt_rx_eop;
        push_entry.mod  = pkt_rx_mod;
        push_entry.err  = pkt_rx_eop & (pkt_rx_err | frm_bad | bad_sop);
      end
    end
  end

  assign pop       = ~empty & out_ready;
  assign frame_inc = push & pkt_rx_eop;
  assign err_inc   = drop | (push & push_entry.err);

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      in_frame <= 1'b0;
      frm_bad  <= 1'b0;
    end else begin
      if (rx_last)                      in_frame <= 1'b0;
      else if (pkt_rx_val && pkt_rx_sop) in_frame <= 1'b1;
      if (frame_inc)    frm_bad <= 1'b0;
      else if (bad_sop) frm_bad <= 1'b1;
    end
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk_156m25) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Gate the head with empty so stale storage never leaks out after reset.
  assign head      = empty ? '0 : mem[rd_ptr];
  assign out_valid = ~empty;
  assign out_data  = head.data;
  assign out_sop   = head.sop;
  assign out_eop   = head.eop;
  assign out_mod   = head.mod;
  assign out_err   = head.err;

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (clr_stats) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_inc && (frame_cnt != '1)) frame_cnt <= frame_cnt + FRM_CNT_W'(1);
      if (err_inc && (err_cnt != '1))     err_cnt   <= err_cnt + ERR_CNT_W'(1);
    end
  end

`ifdef XGEMAC_RX_READER_BYTE_CNT_EN
  logic [3:0] byte_add;
  assign byte_add = (!pkt_rx_eop || (pkt_rx_mod == 3'd0)) ? 4'd8 : {1'b0, pkt_rx_mod};

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n)  byte_cnt <= '0;
    else if (clr_stats)   byte_cnt <= '0;
    else if (push)        byte_cnt <= byte_cnt + 48'(byte_add);
  end
`endif

endmodule

// File: tb/tb_xgemac_rx_pkt_reader.sv
// Directed self-checking bench for xgemac_rx_pkt_reader with a small MAC model answering pkt_rx_ren.
module tb_xgemac_rx_pkt_reader;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
  } word_t;

  logic        clk_156m25 = 1'b0;
  logic        reset_156m25_n;
  logic        pkt_rx_avail, pkt_rx_ren, pkt_rx_val;
  logic [63:0] pkt_rx_data;
  logic        pkt_rx_sop, pkt_rx_eop, pkt_rx_err;
  logic [2:0]  pkt_rx_mod;
  logic        out_valid, out_ready, out_sop, out_eop, out_err;
  logic [63:0] out_data;
  logic [2:0]  out_mod;
  logic        clr_stats;
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;
`ifdef XGEMAC_RX_READER_BYTE_CNT_EN
  logic [47:0] byte_cnt;
`endif

  word_t src[$];
  word_t exp_q[$];
  word_t recv[$];
  word_t force_w;
  logic  force_val;
  logic  ren_pending;
  logic  rdy;
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk_156m25 = ~clk_156m25;

  xgemac_rx_pkt_reader dut (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .pkt_rx_avail   (pkt_rx_avail),
    .pkt_rx_ren     (pkt_rx_ren),
    .pkt_rx_val     (pkt_rx_val),
    .pkt_rx_data    (pkt_rx_data),
    .pkt_rx_sop     (pkt_rx_sop),
    .pkt_rx_eop     (pkt_rx_eop),
    .pkt_rx_mod     (pkt_rx_mod),
    .pkt_rx_err     (pkt_rx_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_mod        (out_mod),
    .out_err        (out_err),
    .clr_stats      (clr_stats),
    .frame_cnt      (frame_cnt),
    .err_cnt        (err_cnt)
`ifdef XGEMAC_RX_READER_BYTE_CNT_EN
    ,
    .byte_cnt       (byte_cnt)
`endif
  );

  // Inputs change on the falling edge; ren and the popped output word are sampled 1 ns later.
  task automatic step();
    word_t w;
    @(negedge clk_156m25);
    w = '0;
    pkt_rx_val = 1'b0;
    if (force_val) begin
      w = force_w;
      pkt_rx_val = 1'b1;
      force_val = 1'b0;
    end else if (ren_pending && (src.size() > 0)) begin
      w = src.pop_front();
      pkt_rx_val = 1'b1;
    end
    pkt_rx_data  = w.data;
    pkt_rx_sop   = w.sop;
    pkt_rx_eop   = w.eop;
    pkt_rx_mod   = w.mod;
    pkt_rx_err   = w.err;
    pkt_rx_avail = (src.size() > 0);
    out_ready    = rdy;
    #1;
    ren_pending = pkt_rx_ren;
    if (out_valid && out_ready)
      recv.push_back(word_t'({out_data, out_sop, out_eop, out_mod, out_err}));
  endtask

  task automatic run_until(input int n, input int budget);
    int c = 0;
    while ((recv.size() < n) && (c < budget)) begin
      step();
      c++;
    end
    n_checks++;
    if (recv.size() < n) begin
      n_fail++;
      $display("[TB] FAIL timeout: got %0d words, required %0d", recv.size(), n);
    end
  endtask

  task automatic load_frame(input int n, input logic [31:0] tag, input logic [2:0] last_mod, input logic last_err);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.data = {tag, 32'(i)};
      w.sop  = (i == 0);
      w.eop  = (i == n - 1);
      w.mod  = w.eop ? last_mod : 3'd0;
      w.err  = w.eop ? last_err : 1'b0;
      src.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic clear_all();
    recv.delete();
    exp_q.delete();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
  endtask

  task automatic test_reset();
    reset_156m25_n = 1'b0;
    repeat (2) step();
    reset_156m25_n = 1'b1;
    step();
    n_checks++;
    if (pkt_rx_ren !== 1'b0) begin n_fail++; $display("[TB] FAIL reset ren: got %b required 0", pkt_rx_ren); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset out_valid: got %b required 0", out_valid); end
    n_checks++;
    if ({out_data, out_sop, out_eop, out_mod, out_err} !== 70'd0) begin
      n_fail++; $display("[TB] FAIL reset out fields: got %h required 0", {out_data, out_sop, out_eop, out_mod, out_err});
    end
    n_checks++;
    if (frame_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset frame_cnt: got %0d required 0", frame_cnt); end
    n_checks++;
    if (err_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset err_cnt: got %0d required 0", err_cnt); end
  endtask

  task automatic test_frame_64();
    clear_all();
    rdy = 1'b1;
    load_frame(8, 32'h0000_6464, 3'd0, 1'b0);
    run_until(8, 60);
    n_checks++;
    if (recv.size() != 8) begin n_fail++; $display("[TB] FAIL f64 count: got %0d required 8", recv.size()); end
    for (int i = 0; (i < exp_q.size()) && (i < recv.size()); i++) begin
      n_checks++;
      if (recv[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL f64 word %0d: got %h required %h", i, recv[i], exp_q[i]); end
    end
    n_checks++;
    if (frame_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL f64 frame_cnt: got %0d required 1", frame_cnt); end
    n_checks++;
    if (err_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL f64 err_cnt: got %0d required 0", err_cnt); end
`ifdef XGEMAC_RX_READER_BYTE_CNT_EN
    n_checks++;
    if (byte_cnt !== 48'd64) begin n_fail++; $display("[TB] FAIL f64 byte_cnt: got %0d required 64", byte_cnt); end
`endif
  endtask

  task automatic test_frame_61();
    clear_all();
    load_frame(8, 32'h0000_6161, 3'd5, 1'b0);
    run_until(8, 60);
    n_checks++;
    if ((recv.size() == 8) ? (recv[7].mod !== 3'd5 || recv[7].eop !== 1'b1) : 1'b1) begin
      n_fail++; $display("[TB] FAIL f61 eop mod: got %0d words, required mod 5 on 8th", recv.size());
    end
    for (int i = 0; (i < exp_q.size()) && (i < recv.size()); i++) begin
      n_checks++;
      if (recv[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL f61 word %0d: got %h required %h", i, recv[i], exp_q[i]); end
    end
    n_checks++;
    if (frame_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL f61 frame_cnt: got %0d required 1", frame_cnt); end
`ifdef XGEMAC_RX_READER_BYTE_CNT_EN
    n_checks++;
    if (byte_cnt !== 48'd61) begin n_fail++; $display("[TB] FAIL f61 byte_cnt: got %0d required 61", byte_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    clear_all();
    rdy = 1'b0;
    load_frame(40, 32'h0000_4040, 3'd0, 1'b0);
    repeat (60) step();
    n_checks++;
    if (recv.size() != 0) begin n_fail++; $display("[TB] FAIL bp popped: got %0d required 0", recv.size()); end
    n_checks++;
    if (src.size() != 24) begin n_fail++; $display("[TB] FAIL bp words read: got %0d required 16", 40 - src.size()); end
    n_checks++;
    if (pkt_rx_ren !== 1'b0) begin n_fail++; $display("[TB] FAIL bp ren stalled: got %b required 0", pkt_rx_ren); end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp out_valid: got %b required 1", out_valid); end
    rdy = 1'b1;
    run_until(40, 200);
    n_checks++;
    if (recv.size() != 40) begin n_fail++; $display("[TB] FAIL bp count: got %0d required 40", recv.size()); end
    for (int i = 0; (i < exp_q.size()) && (i < recv.size()); i++) begin
      n_checks++;
      if (recv[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL bp word %0d: got %h required %h", i, recv[i], exp_q[i]); end
    end
    n_checks++;
    if (err_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL bp err_cnt: got %0d required 0", err_cnt); end
    n_checks++;
    if (frame_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL bp frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_rx_err();
    clear_all();
    load_frame(3, 32'h0000_0e44, 3'd6, 1'b1);
    run_until(3, 40);
    for (int i = 0; (i < 3) && (i < recv.size()); i++) begin
      n_checks++;
      if (recv[i].err !== (i == 2)) begin n_fail++; $display("[TB] FAIL rxerr out_err word %0d: got %b required %b", i, recv[i].err, (i == 2)); end
    end
    n_checks++;
    if (err_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL rxerr err_cnt: got %0d required 1", err_cnt); end
    n_checks++;
    if (frame_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL rxerr frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_framing();
    word_t w;
    clear_all();
    force_w   = '{data: 64'hdead_beef_0000_0001, sop: 1'b0, eop: 1'b0, mod: 3'd0, err: 1'b0};
    force_val = 1'b1;
    repeat (5) step();
    n_checks++;
    if (recv.size() != 0) begin n_fail++; $display("[TB] FAIL nosop output: got %0d words required 0", recv.size()); end
    n_checks++;
    if (err_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL nosop err_cnt: got %0d required 1", err_cnt); end
    for (int i = 0; i < 4; i++) begin
      w = '{data: {32'h0000_5050, 32'(i)}, sop: (i == 0) || (i == 2), eop: (i == 3), mod: (i == 3) ? 3'd2 : 3'd0, err: 1'b0};
      src.push_back(w);
      w.sop = (i == 0);
      w.err = (i == 3);
      exp_q.push_back(w);
    end
    run_until(4, 40);
    for (int i = 0; (i < exp_q.size()) && (i < recv.size()); i++) begin
      n_checks++;
      if (recv[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL midsop word %0d: got %h required %h", i, recv[i], exp_q[i]); end
    end
    n_checks++;
    if (err_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL midsop err_cnt: got %0d required 2", err_cnt); end
    n_checks++;
    if (frame_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL midsop frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_all();
    load_frame(2, 32'h0000_b1b1, 3'd4, 1'b0);
    load_frame(3, 32'h0000_b2b2, 3'd7, 1'b0);
    run_until(5, 60);
    for (int i = 0; (i < exp_q.size()) && (i < recv.size()); i++) begin
      n_checks++;
      if (recv[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL b2b word %0d: got %h required %h", i, recv[i], exp_q[i]); end
    end
    n_checks++;
    if (frame_cnt !== 32'd2) begin n_fail++; $display("[TB] FAIL b2b frame_cnt: got %0d required 2", frame_cnt); end
`ifdef XGEMAC_RX_READER_BYTE_CNT_EN
    n_checks++;
    if (byte_cnt !== 48'd35) begin n_fail++; $display("[TB] FAIL b2b byte_cnt: got %0d required 35", byte_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    int c = 0;
    clear_all();
    rdy = 1'b0;
    load_frame(8, 32'h0000_7777, 3'd0, 1'b0);
    while ((src.size() > 5) && (c < 50)) begin
      step();
      c++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid pre-reset out_valid: got %b required 1", out_valid); end
    #2 reset_156m25_n = 1'b0;
    #1;
    n_checks++;
    if ({pkt_rx_ren, out_valid} !== 2'b00) begin n_fail++; $display("[TB] FAIL rstmid ren/valid: got %b required 00", {pkt_rx_ren, out_valid}); end
    n_checks++;
    if ({out_data, out_sop, out_eop, out_mod, out_err} !== 70'd0) begin
      n_fail++; $display("[TB] FAIL rstmid out fields: got %h required 0", {out_data, out_sop, out_eop, out_mod, out_err});
    end
    src.delete();
    exp_q.delete();
    recv.delete();
    ren_pending  = 1'b0;
    pkt_rx_val   = 1'b0;
    pkt_rx_avail = 1'b0;
    #20 reset_156m25_n = 1'b1;
    rdy = 1'b1;
    load_frame(4, 32'h0000_8888, 3'd3, 1'b0);
    run_until(4, 40);
    for (int i = 0; (i < exp_q.size()) && (i < recv.size()); i++) begin
      n_checks++;
      if (recv[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL rstmid word %0d: got %h required %h", i, recv[i], exp_q[i]); end
    end
    n_checks++;
    if (frame_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL rstmid frame_cnt: got %0d required 1", frame_cnt); end
    n_checks++;
    if (err_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL rstmid err_cnt: got %0d required 0", err_cnt); end
  endtask

  initial begin
    reset_156m25_n = 1'b0;
    pkt_rx_avail = 1'b0;
    pkt_rx_val   = 1'b0;
    pkt_rx_data  = '0;
    pkt_rx_sop   = 1'b0;
    pkt_rx_eop   = 1'b0;
    pkt_rx_mod   = '0;
    pkt_rx_err   = 1'b0;
    out_ready    = 1'b1;
    clr_stats    = 1'b0;
    force_val    = 1'b0;
    force_w      = '0;
    ren_pending  = 1'b0;
    rdy          = 1'b1;
    test_reset();
    test_frame_64();
    test_frame_61();
    test_backpressure();
    test_rx_err();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
